// File: rtl/bist_pkg.sv
// Shared types and constants for the ALU BIST output response analyzer.
package bist_pkg;

  localparam int unsigned MISR_W = 17;

  // Feedback taps for x^17 + x^3 + 1: the MSB folds back into bits 0 and 3.
  localparam logic [MISR_W-1:0] MISR_POLY = 17'h00009;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CMP,
    DONE
  } state_t;

endpackage

// File: rtl/misr_17bit.sv
// 17-bit multiple-input signature register with a synchronous seed load.
import bist_pkg::*;

module misr_17bit (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [MISR_W-1:0] seed,
  input  logic [MISR_W-1:0] d,
  output logic [MISR_W-1:0] q
);

  logic [MISR_W-1:0] nxt;

  always_comb begin
    nxt = {q[MISR_W-2:0], 1'b0} ^ (q[MISR_W-1] ? MISR_POLY : '0) ^ d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// Compacts {cout, result} into a MISR for N_PATTERNS cycles, then checks the golden signature.
import bist_pkg::*;

module bist_misr_analyzer #(
  parameter int unsigned       N_PATTERNS = 256,
  parameter logic [MISR_W-1:0] SEED       = 17'h00000,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 17'h00000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       result,
  input  logic              cout,
  output logic [MISR_W-1:0] sig,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam logic [15:0] LAST_CNT = 16'(N_PATTERNS - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] count_q;
  logic        pass_q;
  logic        load_en;
  logic        cap_en;
  logic        start_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    cap_en    = 1'b0;
    start_acc = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        load_en = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        cap_en = 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = CMP;
        end
      end
      CMP: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          start_acc = 1'b1;
          state_d   = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter runs one past LAST_CNT on the final capture; 16 bits cover N_PATTERNS=65535 without wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_en) begin
      count_q <= '0;
    end else if (cap_en) begin
      count_q <= count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if (start_acc) begin
      pass_q <= 1'b0;
    end else if (state_q == CMP) begin
      pass_q <= (sig == GOLDEN_SIG);
    end
  end

  assign pass = pass_q;

  misr_17bit u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (load_en),
    .en   (cap_en),
    .seed (SEED),
    .d    ({cout, result}),
    .q    (sig)
  );

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Directed and randomized checks of bist_misr_analyzer against a polynomial-division signature model.
module tb_bist_misr_analyzer;

  logic        clk;
  logic        rst;
  logic [15:0] result;
  logic        cout;
  logic        start_v [4];
  logic [16:0] sig_o   [4];
  logic        busy_o  [4];
  logic        done_o  [4];
  logic        pass_o  [4];

  int unsigned checks;
  int unsigned errors;

  logic [16:0] pat [512];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bist_misr_analyzer #(.N_PATTERNS(256), .SEED(17'h0ACE5), .GOLDEN_SIG(17'h00000)) u_main (
    .clk(clk), .rst(rst), .start(start_v[0]), .result(result), .cout(cout),
    .sig(sig_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]));

  bist_misr_analyzer #(.N_PATTERNS(2), .SEED(17'h00000), .GOLDEN_SIG(17'h00002)) u_shift (
    .clk(clk), .rst(rst), .start(start_v[1]), .result(result), .cout(cout),
    .sig(sig_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]));

  bist_misr_analyzer #(.N_PATTERNS(1), .SEED(17'h10000), .GOLDEN_SIG(17'h00009)) u_fb (
    .clk(clk), .rst(rst), .start(start_v[2]), .result(result), .cout(cout),
    .sig(sig_o[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]));

  bist_misr_analyzer #(.N_PATTERNS(4), .SEED(17'h00000), .GOLDEN_SIG(17'h00000)) u_fail (
    .clk(clk), .rst(rst), .start(start_v[3]), .result(result), .cout(cout),
    .sig(sig_o[3]), .busy(busy_o[3]), .done(done_o[3]), .pass(pass_o[3]));

  // Signature as remainder arithmetic: multiply by x modulo x^17+x^3+1, then add the data word.
  function automatic logic [16:0] sig_step(input logic [16:0] s, input logic [16:0] d);
    logic [17:0] t;
    t = {s, 1'b0};
    if (t[17]) t = t ^ 18'h20009;
    return t[16:0] ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run on instance id; patterns come from pat[0..n-1].
  task automatic run(input int id, input int n, input logic [16:0] seed, input bit pulse_mid,
                     output logic [16:0] model);
    model = seed;
    for (int k = 0; k < n; k++) model = sig_step(model, pat[k]);
    start_v[id] = 1'b1;
    tick();
    start_v[id] = 1'b0;
    chk("busy_after_start", 32'(busy_o[id]), 32'd1);
    chk("done_clr_after_start", 32'(done_o[id]), 32'd0);
    chk("pass_clr_after_start", 32'(pass_o[id]), 32'd0);
    tick();
    chk("sig_seed_loaded", 32'(sig_o[id]), 32'(seed));
    for (int k = 0; k < n; k++) begin
      {cout, result} = pat[k];
      if (pulse_mid && k == n / 2) start_v[id] = 1'b1;
      tick();
      start_v[id] = 1'b0;
    end
    {cout, result} = 17'(~$urandom);
    chk("busy_in_cmp", 32'(busy_o[id]), 32'd1);
    chk("done_low_in_cmp", 32'(done_o[id]), 32'd0);
    tick();
    chk("done_at_latency", 32'(done_o[id]), 32'd1);
    chk("busy_low_in_done", 32'(busy_o[id]), 32'd0);
    chk("sig_vs_model", 32'(sig_o[id]), 32'(model));
    tick();
    chk("sig_held_in_done", 32'(sig_o[id]), 32'(model));
    chk("done_held", 32'(done_o[id]), 32'd1);
  endtask

  initial begin
    logic [16:0] m;
    logic [16:0] m_good;
    logic [15:0] lfsr;
    logic [15:0] a;
    logic [15:0] b;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    result = '0;
    cout = 1'b0;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_sig", 32'(sig_o[i]), 32'd0);
      chk("rst_busy", 32'(busy_o[i]), 32'd0);
      chk("rst_done", 32'(done_o[i]), 32'd0);
      chk("rst_pass", 32'(pass_o[i]), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      {cout, result} = 17'($urandom);
      tick();
      chk("idle_sig", 32'(sig_o[0]), 32'd0);
      chk("idle_busy", 32'(busy_o[0]), 32'd0);
      chk("idle_done", 32'(done_o[0]), 32'd0);
    end

    // Shift check: done exactly 4 cycles after start
    pat[0] = 17'h00001;
    pat[1] = 17'h00000;
    run(1, 2, 17'h00000, 1'b0, m);
    chk("shift_sig", 32'(sig_o[1]), 32'h00002);
    chk("shift_pass", 32'(pass_o[1]), 32'd1);

    // Feedback check
    pat[0] = 17'h00000;
    run(2, 1, 17'h10000, 1'b0, m);
    chk("fb_sig", 32'(sig_o[2]), 32'h00009);
    chk("fb_pass", 32'(pass_o[2]), 32'd1);

    // Fail detection
    pat[0] = 17'h00000;
    pat[1] = 17'h10000;
    pat[2] = 17'h00000;
    pat[3] = 17'h00000;
    run(3, 4, 17'h00000, 1'b0, m);
    chk("fail_pass", 32'(pass_o[3]), 32'd0);
    chk("fail_done", 32'(done_o[3]), 32'd1);

    // Restart from DONE with an ignored mid-run start pulse
    pat[0] = 17'h00001;
    pat[1] = 17'h00000;
    run(1, 2, 17'h00000, 1'b1, m);
    chk("rerun_sig", 32'(sig_o[1]), 32'h00002);
    chk("rerun_pass", 32'(pass_o[1]), 32'd1);

    // Golden regression: LFSR-driven adder responses
    lfsr = 16'hACE1;
    for (int k = 0; k < 256; k++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      a = lfsr;
      b = {lfsr[7:0], lfsr[15:8]};
      pat[k] = {1'b0, a} + {1'b0, b};
    end
    run(0, 256, 17'h0ACE5, 1'b1, m_good);
    chk("gold_pass", 32'(pass_o[0]), 32'(m_good == 17'h0));
    run(0, 256, 17'h0ACE5, 1'b0, m);
    chk("gold_rerun_same", 32'(sig_o[0]), 32'(m_good));

    // Stuck-at-0 on result bit 0
    for (int k = 0; k < 256; k++) pat[k][0] = 1'b0;
    run(0, 256, 17'h0ACE5, 1'b0, m);
    chk("stuck_sig_differs", 32'(sig_o[0] != m_good), 32'd1);
    chk("stuck_pass", 32'(pass_o[0]), 32'(m == 17'h0));

    // Random responses whose final word cancels the signature to the golden value 0
    m = 17'h0ACE5;
    for (int k = 0; k < 255; k++) begin
      pat[k] = 17'($urandom);
      m = sig_step(m, pat[k]);
    end
    pat[255] = sig_step(m, 17'h0);
    run(0, 256, 17'h0ACE5, 1'b0, m);
    chk("zero_sig", 32'(sig_o[0]), 32'd0);
    chk("zero_pass", 32'(pass_o[0]), 32'd1);

    // Mid-run reset aborts back to IDLE
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      {cout, result} = 17'($urandom);
      tick();
    end
    chk("midrun_busy", 32'(busy_o[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sig", 32'(sig_o[0]), 32'd0);
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_done", 32'(done_o[0]), 32'd0);
    chk("abort_pass", 32'(pass_o[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      {cout, result} = 17'($urandom);
      tick();
      chk("abort_stays_idle", 32'(busy_o[0] | done_o[0]), 32'd0);
      chk("abort_sig_held", 32'(sig_o[0]), 32'd0);
    end

    // Clean run after the abort
    for (int k = 0; k < 256; k++) pat[k] = 17'($urandom);
    run(0, 256, 17'h0ACE5, 1'b0, m);
    chk("post_abort_pass", 32'(pass_o[0]), 32'(m == 17'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_misr_analyzer.md
# bist_misr_analyzer

Output response analyzer for the 16-bit ALU BIST loop. Sits directly downstream of the ALU under test and compacts `{cout, result}` into a 17-bit multiple-input signature register (MISR) once per clock for a fixed number of test patterns. At the end of the run it compares the signature against a golden value and reports pass/fail. The BIST controller starts it in the same cycle it starts the upstream LFSR pattern generator.

## Interface
Parameters:
- `N_PATTERNS`, default 256. Number of ALU responses compacted per run. Legal range is 1..65535.
- `SEED`, default 17'h00000. MISR value loaded at run start.
- `GOLDEN_SIG`, default 17'h00000. Expected final signature. It is overridden per build from the fault-free simulation.

Ports:
- `clk`, input, 1 bit. Single clock.
- `rst`, input, 1 bit. Synchronous, active-high reset.
- `start`, input, 1 bit. One-cycle pulse. Sampled only in IDLE and DONE.
- `result`, input, 16 bits. ALU result.
- `cout`, input, 1 bit. ALU carry out.
- `sig`, output, 17 bits. Current MISR contents.
- `busy`, output, 1 bit. High in LOAD, RUN and CMP.
- `done`, output, 1 bit. High in DONE.
- `pass`, output, 1 bit. Registered compare result. Valid while `done`=1.

## Operation
- Data vector: d[16:0] = {cout, result}.
- MISR characteristic polynomial: x^17 + x^3 + 1.
- MISR update, one step per clock:
  - nxt[0] = sig[16] ^ d[0]
  - nxt[3] = sig[2] ^ d[3] ^ sig[16]
  - nxt[i] = sig[i-1] ^ d[i] for every other i in 1..16
- Pattern counter: 16 bits, counts 0..N_PATTERNS-1.
- States:
  - IDLE: `start` moves to LOAD.
  - LOAD: one cycle. sig <= SEED, count <= 0. Then moves to RUN.
  - RUN: each cycle sig <= nxt and count increments. On the capture where count == N_PATTERNS-1, moves to CMP.
  - CMP: one cycle. pass <= (sig == GOLDEN_SIG). Then moves to DONE.
  - DONE: holds `sig`, `pass` and `done`. `start` moves to LOAD, which clears `done` and `pass`.
- `start` is ignored in LOAD, RUN and CMP.
- No back-pressure and no input valid. In RUN, every clock is a capture. The upstream stage must present a new pattern each cycle beginning with the first RUN cycle.

## Timing
- Reset values: state=IDLE, sig=17'h0, count=0, busy=0, done=0, pass=0.
- Reset is sampled at every edge and overrides all activity. Asserting `rst` mid-RUN or mid-CMP aborts the run and returns to IDLE on the next edge, with no partial result.
- `start` high at edge E:
  - LOAD is entered at E.
  - RUN is entered at E+1.
  - Captures occur at edges E+2 through E+1+N_PATTERNS, inclusive.
  - CMP is entered at E+1+N_PATTERNS.
  - DONE is entered, with `done`=1 and `pass` valid, at E+2+N_PATTERNS.
- Total run latency is N_PATTERNS+2 cycles from the `start` edge to `done`.
- `busy` rises at E and falls at E+2+N_PATTERNS.
- `sig` is a registered output and changes only on capture or LOAD.
- Counter width: 16 bits. With N_PATTERNS=65535 the counter must not wrap before leaving RUN.
- `start` high in DONE behaves the same as `start` high in IDLE.

## Structure
- Package `bist_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, CMP, DONE)
  - `MISR_W`=17
  - the tap constant `MISR_POLY`=17'h00009, marking the feedback taps of bits 0 and 3
- The MISR datapath is its own sub-module, `misr_17bit`, with ports clk, rst, load, en, seed, d and q.
- The top level holds the FSM, the counter and the compare.

## Test plan
- Reset, then idle: `rst` for 2 cycles. Required: sig=0, busy=0, done=0, pass=0, and all stay there with `start`=0.
- Shift check: N_PATTERNS=2, SEED=0, inputs {cout,result}=17'h00001 then 17'h00000. Required: sig=17'h00002, done rises exactly 4 cycles after the `start` edge, and pass=1 with GOLDEN_SIG=17'h00002.
- Feedback check: N_PATTERNS=1, SEED=17'h10000, input 0. Required: sig=17'h00009.
- Fail detection: N_PATTERNS=4, GOLDEN_SIG=17'h00000, one input pattern with cout=1. Required: pass=0 and done=1.
- Mid-run reset and restart:
  - Assert `rst` during RUN. Required: IDLE next cycle, all outputs at reset values.
  - Pulse `start` during RUN. Required: ignored, with count and latency unchanged.
  - Pulse `start` in DONE. Required: clean rerun with an identical signature.
- Golden regression: drive the ALU from the LFSR for 256 patterns. Required: sig equals GOLDEN_SIG from the fault-free run and pass=1. With the ALU bit-0 result stuck-at-0, required pass=0.
